// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control with memory wait, halt drain, timeout flag and perf counters for a 5-stage RV32 pipeline.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS = 5,
  parameter int CNT_W = 32,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_halt,
  input  logic                  ex_redirect,
  input  logic                  mem_busy,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic                  memwb_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halted,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int BW = $clog2(MAX_MEM_WAIT + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic v_ex, v_mem, v_wb, rw_ex, rw_mem, rw_wb, mr_ex;
  logic [RF_ADDRESS-1:0] rd_ex, rd_mem, rd_wb, rs1_ex, rs2_ex;
  logic [BW-1:0] busy_cnt;
  logic load_use, lu_ok, redir_ok;
  assign load_use = id_valid & v_ex & mr_ex & (|rd_ex) &
                    ((id_uses_rs1 & (id_rs1 == rd_ex)) | (id_uses_rs2 & (id_rs2 == rd_ex)));
  // MEM result is younger than WB data, so it wins; x0 is never forwarded
  assign fwd_a = reset ? 2'b00 :
                 (v_mem & rw_mem & (|rd_mem) & (rd_mem == rs1_ex)) ? 2'b10 :
                 (v_wb & rw_wb & (|rd_wb) & (rd_wb == rs1_ex)) ? 2'b01 : 2'b00;
  assign fwd_b = reset ? 2'b00 :
                 (v_mem & rw_mem & (|rd_mem) & (rd_mem == rs2_ex)) ? 2'b10 :
                 (v_wb & rw_wb & (|rd_wb) & (rd_wb == rs2_ex)) ? 2'b01 : 2'b00;
  always_comb begin
    state_n = state;
    pc_hold = 1'b0;
    ifid_hold = 1'b0;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold = 1'b0;
    memwb_bubble = 1'b0;
    halted = 1'b0;
    lu_ok = 1'b0;
    redir_ok = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pc_hold = 1'b1;
            ifid_hold = 1'b1;
            exmem_hold = 1'b1;
            memwb_bubble = 1'b1;
          end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
            redir_ok = 1'b1;
          end else if (load_use) begin
            pc_hold = 1'b1;
            ifid_hold = 1'b1;
            idex_bubble = 1'b1;
            lu_ok = 1'b1;
          end else if (id_valid && id_halt) begin
            pc_hold = 1'b1;
            ifid_flush = 1'b1;
            idex_bubble = 1'b1;
            state_n = DRAIN;
          end
        end
        DRAIN: begin
          pc_hold = 1'b1;
          ifid_flush = 1'b1;
          if (mem_busy) begin
            exmem_hold = 1'b1;
            memwb_bubble = 1'b1;
          end else if (ex_redirect) begin
            pc_hold = 1'b0;
            idex_bubble = 1'b1;
            redir_ok = 1'b1;
            state_n = RUN;
          end else begin
            idex_bubble = 1'b1;
            state_n = (!v_ex && !v_mem && !v_wb) ? HALTED : DRAIN;
          end
        end
        HALTED: begin
          halted = 1'b1;
          pc_hold = 1'b1;
          ifid_flush = 1'b1;
          idex_bubble = 1'b1;
          memwb_bubble = 1'b1;
        end
        default: state_n = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      {v_ex, v_mem, v_wb, rw_ex, rw_mem, rw_wb, mr_ex} <= '0;
      {rd_ex, rd_mem, rd_wb, rs1_ex, rs2_ex} <= '0;
      busy_cnt <= '0;
      mem_timeout <= 1'b0;
      retire_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      v_wb <= v_mem & ~memwb_bubble;
      if (!exmem_hold) begin
        rd_wb <= rd_mem;
        rw_wb <= rw_mem;
        v_mem <= v_ex;
        rd_mem <= rd_ex;
        rw_mem <= rw_ex;
        v_ex <= id_valid & ~idex_bubble;
        rd_ex <= id_rd;
        rw_ex <= id_regwrite;
        mr_ex <= id_memread;
        rs1_ex <= id_rs1;
        rs2_ex <= id_rs2;
      end
      if (v_wb && !mem_busy && !(&retire_cnt)) retire_cnt <= retire_cnt + 1'b1;
      if ((lu_ok || exmem_hold) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (redir_ok && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
      busy_cnt <= !mem_busy ? '0 : (busy_cnt == BW'(MAX_MEM_WAIT)) ? busy_cnt : busy_cnt + 1'b1;
      if (mem_busy && busy_cnt >= BW'(MAX_MEM_WAIT - 1)) mem_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scenario bench for pipe_hazard_ctrl with a queue of expected values per scenario.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread, id_halt, ex_redirect, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, halted, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] retire_cnt, stall_cnt, flush_cnt;
  logic pc_hold4, ifid_hold4, ifid_flush4, idex_bubble4, exmem_hold4, memwb_bubble4, halted4, mem_timeout4;
  logic [1:0] fwd_a4, fwd_b4;
  logic [3:0] retire_cnt4, stall_cnt4, flush_cnt4;
  logic [6:0] ctl;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble, halted};
  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .halted(halted), .mem_timeout(mem_timeout), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );
  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_hold(pc_hold4), .ifid_hold(ifid_hold4), .ifid_flush(ifid_flush4), .idex_bubble(idex_bubble4),
    .exmem_hold(exmem_hold4), .memwb_bubble(memwb_bubble4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
    .halted(halted4), .mem_timeout(mem_timeout4), .retire_cnt(retire_cnt4), .stall_cnt(stall_cnt4),
    .flush_cnt(flush_cnt4)
  );
  task automatic put(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic rw, input logic mr, input logic h);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw; id_memread = mr; id_halt = h;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mem_busy = 1'b0; ex_redirect = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_busy = 1'b1; ex_redirect = 1'b1;
    put(1, 5, 5, 5, 1, 1, 1, 1, 1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL reset_ctl got %h exp %h", ctl, e); end
    e = exp_q.pop_front(); tests++;
    if (32'({fwd_a, fwd_b}) !== e) begin fails++; $display("FAIL reset_fwd got %h exp %h", {fwd_a, fwd_b}, e); end
    @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if ((retire_cnt | stall_cnt | flush_cnt) !== e) begin
      fails++; $display("FAIL reset_cnt got %0d/%0d/%0d exp %0d", retire_cnt, stall_cnt, flush_cnt, e);
    end
    e = exp_q.pop_front(); tests++;
    if (32'({halted, mem_timeout}) !== e) begin fails++; $display("FAIL reset_flags got %b%b exp %0d", halted, mem_timeout, e); end
    reset = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_load_use();
    do_reset();
    put(1, 5, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    put(1, 6, 5, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(32'h68);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL lu_stall got %h exp %h", ctl, e); end
    @(negedge clk);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL lu_release got %h exp %h", ctl, e); end
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h1);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(fwd_a) !== e) begin fails++; $display("FAIL lu_fwd_a got %b exp %0d", fwd_a, e); end
    e = exp_q.pop_front(); tests++;
    if (stall_cnt !== e) begin fails++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, e); end
  endtask
  task automatic test_forward();
    int rd1[4] = '{3, 0, 3, 3};
    int rd2[4] = '{3, 0, 4, 3};
    int rw2[4] = '{1, 1, 1, 0};
    int rs2[4] = '{3, 0, 3, 3};
    int fb[4] = '{2, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      put(1, 5'(rd1[k]), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      put(1, 5'(rd2[k]), 0, 0, 0, 0, rw2[k] != 0, 0, 0);
      @(negedge clk);
      put(1, 7, 0, 5'(rs2[k]), 0, 1, 0, 0, 0);
      exp_q.push_back(32'(fb[k]));
      @(negedge clk);
      put(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      e = exp_q.pop_front(); tests++;
      if (32'(fwd_b) !== e) begin fails++; $display("FAIL fwd_b_case%0d got %b exp %0d", k, fwd_b, e); end
      tests++;
      if (fwd_a !== 2'b00) begin fails++; $display("FAIL fwd_a_x0_case%0d got %b exp 0", k, fwd_a); end
    end
  endtask
  task automatic test_redirect_lu();
    do_reset();
    put(1, 5, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    put(1, 6, 5, 0, 1, 0, 1, 0, 0);
    ex_redirect = 1'b1;
    exp_q.push_back(32'h18);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL redir_lu_ctl got %h exp %h", ctl, e); end
    @(negedge clk);
    ex_redirect = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h1); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (flush_cnt !== e) begin fails++; $display("FAIL redir_flush_cnt got %0d exp %0d", flush_cnt, e); end
    e = exp_q.pop_front(); tests++;
    if (stall_cnt !== e) begin fails++; $display("FAIL redir_stall_cnt got %0d exp %0d", stall_cnt, e); end
  endtask
  task automatic test_mem_busy();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(1, 5'(i + 1), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h66); exp_q.push_back(32'(i >= 15));
      #1;
      e = exp_q.pop_front(); tests++;
      if (32'(ctl) !== e) begin fails++; $display("FAIL busy_ctl_cyc%0d got %h exp %h", i, ctl, e); end
      e = exp_q.pop_front(); tests++;
      if (32'(mem_timeout) !== e) begin fails++; $display("FAIL busy_timeout_cyc%0d got %b exp %0d", i, mem_timeout, e); end
      @(negedge clk);
    end
    mem_busy = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'd0); exp_q.push_back(32'd16);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL busy_release_ctl got %h exp %h", ctl, e); end
    e = exp_q.pop_front(); tests++;
    if (retire_cnt !== e) begin fails++; $display("FAIL busy_retire got %0d exp %0d", retire_cnt, e); end
    e = exp_q.pop_front(); tests++;
    if (stall_cnt !== e) begin fails++; $display("FAIL busy_stall_cnt got %0d exp %0d", stall_cnt, e); end
    repeat (3) @(negedge clk);
    exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); tests++;
    if (retire_cnt !== e) begin fails++; $display("FAIL busy_after_retire got %0d exp %0d", retire_cnt, e); end
    e = exp_q.pop_front(); tests++;
    if (32'(mem_timeout) !== e) begin fails++; $display("FAIL timeout_sticky got %b exp %0d", mem_timeout, e); end
  endtask
  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put(1, 5'(i + 1), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    put(1, 0, 0, 0, 0, 0, 0, 0, 1);
    exp_q.push_back(32'h58);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL halt_issue_ctl got %h exp %h", ctl, e); end
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h58);
      #1;
      e = exp_q.pop_front(); tests++;
      if (32'(ctl) !== e) begin fails++; $display("FAIL drain_ctl_cyc%0d got %h exp %h", i, ctl, e); end
      @(negedge clk);
    end
    exp_q.push_back(32'h5B); exp_q.push_back(32'd3);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL halted_ctl got %h exp %h", ctl, e); end
    e = exp_q.pop_front(); tests++;
    if (retire_cnt !== e) begin fails++; $display("FAIL halt_retire got %0d exp %0d", retire_cnt, e); end
    ex_redirect = 1'b1;
    @(negedge clk);
    ex_redirect = 1'b0;
    exp_q.push_back(32'h5B); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL halted_sticky got %h exp %h", ctl, e); end
    e = exp_q.pop_front(); tests++;
    if (flush_cnt !== e) begin fails++; $display("FAIL halted_no_flush got %0d exp %0d", flush_cnt, e); end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      put(1, 5'(i + 1), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    put(1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 1'b1;
    exp_q.push_back(32'h18);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL drain_redir_ctl got %h exp %h", ctl, e); end
    @(negedge clk);
    ex_redirect = 1'b0;
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); tests++;
    if (flush_cnt !== e) begin fails++; $display("FAIL drain_redir_flush got %0d exp %0d", flush_cnt, e); end
    repeat (4) @(negedge clk);
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'(ctl) !== e) begin fails++; $display("FAIL drain_redir_run got %h exp %h", ctl, e); end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      put(1, 5'(i % 31 + 1), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    exp_q.push_back(32'd20); exp_q.push_back(32'd15);
    #1;
    e = exp_q.pop_front(); tests++;
    if (retire_cnt !== e) begin fails++; $display("FAIL retire_20 got %0d exp %0d", retire_cnt, e); end
    e = exp_q.pop_front(); tests++;
    if (32'(retire_cnt4) !== e) begin fails++; $display("FAIL retire_sat got %0d exp %0d", retire_cnt4, e); end
    for (int i = 0; i < 3; i++) begin
      put(1, 5'(i + 1), 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
    end
    mem_busy = 1'b1;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests++;
    if (32'({retire_cnt4, stall_cnt4, flush_cnt4}) !== e) begin
      fails++; $display("FAIL sat_reset_cnt got %0d/%0d/%0d exp %0d", retire_cnt4, stall_cnt4, flush_cnt4, e);
    end
    e = exp_q.pop_front(); tests++;
    if (32'({mem_timeout, mem_timeout4, halted, retire_cnt != 0}) !== e) begin
      fails++; $display("FAIL mid_reset_flags got %b%b%b retire %0d exp %0d", mem_timeout, mem_timeout4, halted, retire_cnt, e);
    end
    reset = 1'b0; mem_busy = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    reset = 1'b1; mem_busy = 1'b0; ex_redirect = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_forward();
    test_redirect_lu();
    test_mem_busy();
    test_halt();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
